// File: rtl/adc_sample_scheduler.sv
// Paces a 4-channel parallel ADC driver and packs the returned channel words into 64-bit frames.
// Define ADC_SCHED_TIMESTAMP_EN to carry a 32-bit tick index alongside each frame.
module adc_sample_scheduler #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned PERIOD_W    = 24,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                drv_start_o,
    input  logic                drv_busy_i,
    input  logic                drv_valid_i,
    input  logic [1:0]          drv_ch_i,
    input  logic [15:0]         drv_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [16*N_CH-1:0]  out_data_o,
    output logic [31:0]         out_tstamp_o,
    output logic [CNT_W-1:0]    overrun_cnt_o,
    output logic [CNT_W-1:0]    drop_cnt_o,
    output logic                timeout_o
);

    localparam int unsigned          TO_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PERIOD_W-1:0]  MIN_PERIOD = PERIOD_W'(64);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_CAPT,
        S_EMIT
    } state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [TO_W-1:0]     tcnt_q, tcnt_d;
    logic [N_CH-1:0]     mask_q, mask_d;
    logic [15:0]         slot_q [N_CH];
    logic                out_valid_q;
    logic [16*N_CH-1:0]  out_data_q;
    logic [CNT_W-1:0]    ovr_q;
    logic [CNT_W-1:0]    drop_q;
    logic                timeout_q;
    logic                en_q;

    logic [PERIOD_W-1:0] eff_period;
    logic                run;
    logic                tick;
    logic [N_CH-1:0]     mask_upd;
    logic [16*N_CH-1:0]  frame;
    logic                capt_we;
    logic                load;
    logic                drop_ev;
    logic                to_set;
    logic                ovr_inc;

    // Period counter only runs once the FSM has left IDLE, so the first tick lands in WAIT.
    always_comb begin
        eff_period = (period_i < MIN_PERIOD) ? MIN_PERIOD : period_i;
        run        = enable_i && (state_q != S_IDLE);
        tick       = run && (cnt_q == '0);
        cnt_d      = cnt_q;
        per_d      = per_q;
        if (!run) begin
            cnt_d = '0;
            per_d = eff_period;
        end else if (cnt_q == per_q - 1'b1) begin
            cnt_d = '0;
            per_d = eff_period;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        mask_upd = mask_q;
        if (drv_valid_i) begin
            mask_upd[drv_ch_i] = 1'b1;
        end
    end

    always_comb begin
        frame = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            frame[16*i +: 16] = slot_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        mask_d  = mask_q;
        capt_we = 1'b0;
        load    = 1'b0;
        drop_ev = 1'b0;
        to_set  = 1'b0;
        ovr_inc = tick && (state_q == S_START || state_q == S_CAPT || state_q == S_EMIT);
        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tick)           state_d = S_START;
                else if (!enable_i) state_d = S_IDLE;
            end
            S_START: begin
                mask_d  = '0;
                tcnt_d  = '0;
                state_d = S_CAPT;
            end
            S_CAPT: begin
                mask_d  = mask_upd;
                capt_we = drv_valid_i;
                tcnt_d  = tcnt_q + 1'b1;
                if ((&mask_upd) && !drv_busy_i) begin
                    state_d = S_EMIT;
                end else if (tcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    to_set  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_EMIT: begin
                if (!out_valid_q || out_ready_i) load    = 1'b1;
                else                             drop_ev = 1'b1;
                state_d = enable_i ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            per_q       <= MIN_PERIOD;
            tcnt_q      <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovr_q       <= '0;
            drop_q      <= '0;
            timeout_q   <= 1'b0;
            en_q        <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            tcnt_q  <= tcnt_d;
            mask_q  <= mask_d;
            en_q    <= enable_i;
            if (capt_we) begin
                slot_q[drv_ch_i] <= drv_data_i;
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= frame;
            end else if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (ovr_inc && !(&ovr_q)) begin
                ovr_q <= ovr_q + 1'b1;
            end
            if (drop_ev && !(&drop_q)) begin
                drop_q <= drop_q + 1'b1;
            end
            if (to_set) begin
                timeout_q <= 1'b1;
            end else if (enable_i && !en_q) begin
                timeout_q <= 1'b0;
            end
        end
    end

`ifdef ADC_SCHED_TIMESTAMP_EN
    logic [31:0] idx_q;
    logic [31:0] stamp_q;
    logic [31:0] out_ts_q;

    // The frame carries the index of the tick that launched it (pre-increment value).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            stamp_q  <= '0;
            out_ts_q <= '0;
        end else begin
            if (tick) begin
                idx_q <= idx_q + 1'b1;
            end
            if (tick && state_q == S_WAIT) begin
                stamp_q <= idx_q;
            end
            if (load) begin
                out_ts_q <= stamp_q;
            end
        end
    end

    assign out_tstamp_o = out_ts_q;
`else
    assign out_tstamp_o = '0;
`endif

    assign drv_start_o   = (state_q == S_START);
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign overrun_cnt_o = ovr_q;
    assign drop_cnt_o    = drop_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler with a reactive ADC driver model and a frame scoreboard.
module tb_adc_sample_scheduler;

    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable_i;
    logic [23:0]       period_i;
    logic              drv_start_o;
    logic              drv_busy_i;
    logic              drv_valid_i;
    logic [1:0]        drv_ch_i;
    logic [15:0]       drv_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [63:0]       out_data_o;
    logic [31:0]       out_tstamp_o;
    logic [CNT_W-1:0]  overrun_cnt_o;
    logic [CNT_W-1:0]  drop_cnt_o;
    logic              timeout_o;

    adc_sample_scheduler #(
        .N_CH        (4),
        .PERIOD_W    (24),
        .TIMEOUT_CYC (4096),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .period_i      (period_i),
        .drv_start_o   (drv_start_o),
        .drv_busy_i    (drv_busy_i),
        .drv_valid_i   (drv_valid_i),
        .drv_ch_i      (drv_ch_i),
        .drv_data_i    (drv_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .out_tstamp_o  (out_tstamp_o),
        .overrun_cnt_o (overrun_cnt_o),
        .drop_cnt_o    (drop_cnt_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [31:0] ts;
        bit          chk_ts;
    } exp_t;

    exp_t        sbq[$];
    int unsigned start_cyc[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    int          reply_delay   = 20;
    int          n_words       = 4;
    bit          rev           = 1'b0;
    bit          dup           = 1'b0;
    bit          sb_on         = 1'b1;
    bit          ts_track      = 1'b1;
    int unsigned start_cnt     = 0;
    int unsigned frm_no        = 0;
    int unsigned last_word_cyc = 0;
    logic [63:0] last_exp      = '0;
    logic        prev_valid    = 1'b0;
    bit          valid_seen    = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_start(input string tag, output int unsigned c);
        bit found;
        found = 1'b0;
        c = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            step(1);
            if (drv_start_o === 1'b1) begin
                found = 1'b1;
                c = cyc;
            end
        end
        total++;
        assert (found) else begin
            bad++;
            $error("FAIL %s observed=no_start expected=start_within_500", tag);
        end
    endtask

    // Driver model: answers each conversion start after reply_delay cycles.
    initial begin : drv_model
        int          ch;
        logic [15:0] w;
        logic [63:0] fr;
        logic [31:0] ts;
        bit          aborted;
        drv_busy_i  = 1'b0;
        drv_valid_i = 1'b0;
        drv_ch_i    = 2'd0;
        drv_data_i  = 16'd0;
        forever begin
            @(posedge clk);
            #2;
            if (rst !== 1'b1 && drv_start_o === 1'b1) begin
                ts = start_cnt;
                start_cnt++;
                start_cyc.push_back(cyc);
                aborted    = 1'b0;
                fr         = '0;
                drv_busy_i = 1'b1;
                for (int i = 0; i < reply_delay; i++) begin
                    if (!aborted) begin
                        @(posedge clk);
                        #2;
                        if (rst) aborted = 1'b1;
                    end
                end
                if (!aborted && dup) begin
                    drv_valid_i = 1'b1;
                    drv_ch_i    = 2'd2;
                    drv_data_i  = 16'hDEAD;
                    @(posedge clk);
                    #2;
                    if (rst) aborted = 1'b1;
                end
                for (int k = 0; k < n_words; k++) begin
                    if (!aborted) begin
                        ch = rev ? 3 - k : k;
                        w  = 16'(16'h1111 * (ch + 1)) ^ {frm_no[7:0], 8'h00};
                        drv_valid_i = 1'b1;
                        drv_ch_i    = 2'(ch);
                        drv_data_i  = w;
                        fr[16*ch +: 16] = w;
                        if (k == n_words - 1 && n_words == 4) begin
                            drv_busy_i    = 1'b0;
                            last_word_cyc = cyc;
                        end
                        @(posedge clk);
                        #2;
                        if (rst) aborted = 1'b1;
                    end
                end
                drv_valid_i = 1'b0;
                drv_busy_i  = 1'b0;
                if (!aborted && n_words == 4) begin
                    last_exp = fr;
                    frm_no++;
                    if (sb_on) sbq.push_back('{data: fr, ts: ts, chk_ts: ts_track});
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid_o === 1'b1) valid_seen = 1'b1;
            if (rst === 1'b0 && sb_on) begin
                if (out_valid_o === 1'b1 && prev_valid !== 1'b1) begin
                    check("valid_latency", 64'(cyc), 64'(last_word_cyc + 2));
                end
                if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
                    total++;
                    assert (sbq.size() > 0) else begin
                        bad++;
                        $error("FAIL unexpected_frame observed=%0h expected=no_frame", out_data_o);
                    end
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        check("frame_data", out_data_o, e.data);
`ifdef ADC_SCHED_TIMESTAMP_EN
                        if (e.chk_ts) check("frame_tstamp", 64'(out_tstamp_o), 64'(e.ts));
`else
                        check("frame_tstamp", 64'(out_tstamp_o), 64'd0);
`endif
                    end
                end
            end
            prev_valid = out_valid_o;
        end
    end

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog observed=still_running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int unsigned s0, s1, s2, a, b, c, d, e, f, g, j, k, l, m, n;
        logic [CNT_W-1:0] ov0;
        logic [63:0]      held;
        int               mism;
        int unsigned      nstarts;

        rst         = 1'b1;
        enable_i    = 1'b0;
        period_i    = 24'd100;
        out_ready_i = 1'b1;
        step(3);
        check("rst_drv_start", 64'(drv_start_o), 64'd0);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_out_data", out_data_o, 64'd0);
        check("rst_tstamp", 64'(out_tstamp_o), 64'd0);
        check("rst_overrun", 64'(overrun_cnt_o), 64'd0);
        check("rst_drop", 64'(drop_cnt_o), 64'd0);
        check("rst_timeout", 64'(timeout_o), 64'd0);
        rst = 1'b0;
        step(20);
        check("idle_no_start", 64'(start_cyc.size()), 64'd0);

        // Nominal 100-cycle period
        enable_i = 1'b1;
        wait_start("t1_s0", s0);
        wait_start("t1_s1", s1);
        wait_start("t1_s2", s2);
        check("t1_spacing_a", 64'(s1 - s0), 64'd100);
        check("t1_spacing_b", 64'(s2 - s1), 64'd100);
        step(40);
        check("t1_overrun", 64'(overrun_cnt_o), 64'd0);
        check("t1_drop", 64'(drop_cnt_o), 64'd0);
        check("t1_timeout", 64'(timeout_o), 64'd0);

        // Short period clamps to 64; new period applies from the next wrap
        period_i = 24'd10;
        rev      = 1'b1;
        dup      = 1'b1;
        wait_start("t2_a", a);
        wait_start("t2_b", b);
        wait_start("t2_c", c);
        check("t2_old_period", 64'(a - s2), 64'd100);
        check("t2_spacing_a", 64'(b - a), 64'd64);
        check("t2_spacing_b", 64'(c - b), 64'd64);
        step(30);

        // Slow driver: one overrun per frame, starts every two periods
        rev         = 1'b0;
        dup         = 1'b0;
        ts_track    = 1'b0;
        period_i    = 24'd100;
        reply_delay = 150;
        wait_start("t3_d", d);
        wait_start("t3_e", e);
        check("t3_overrun_e", 64'(overrun_cnt_o), 64'd1);
        wait_start("t3_f", f);
        check("t3_overrun_f", 64'(overrun_cnt_o), 64'd2);
        check("t3_spacing_a", 64'(e - d), 64'd200);
        check("t3_spacing_b", 64'(f - e), 64'd200);
        step(160);

        // Back-pressure: first frame held, later two dropped
        reply_delay = 20;
        sb_on       = 1'b0;
        out_ready_i = 1'b0;
        wait_start("t4_g", g);
        step(30);
        held = last_exp;
        mism = 0;
        for (int i = 0; i < 220; i++) begin
            step(1);
            if (out_valid_o !== 1'b1 || out_data_o !== held) mism++;
        end
        check("t4_hold_stable", 64'(mism), 64'd0);
        check("t4_drop", 64'(drop_cnt_o), 64'd2);
        out_ready_i = 1'b1;
        step(2);
        check("t4_valid_fall", 64'(out_valid_o), 64'd0);
        sb_on = 1'b1;

        // Missing channel: timeout, discard, restart on next tick
        wait_start("t5_j", j);
        step(30);
        n_words = 3;
        wait_start("t5_k", k);
        valid_seen = 1'b0;
        ov0 = overrun_cnt_o;
        step(4096);
        check("t5_timeout_before", 64'(timeout_o), 64'd0);
        step(1);
        check("t5_timeout_set", 64'(timeout_o), 64'd1);
        check("t5_no_valid", 64'(valid_seen), 64'd0);
        check("t5_overruns", 64'(overrun_cnt_o - ov0), 64'd40);
        n_words = 4;
        wait_start("t5_l", l);
        check("t5_restart", 64'(l - k), 64'd4100);
        step(40);
        check("t5_timeout_sticky", 64'(timeout_o), 64'd1);
        enable_i = 1'b0;
        nstarts  = start_cyc.size();
        step(150);
        check("t5_disabled_no_start", 64'(start_cyc.size()), 64'(nstarts));
        check("t5_timeout_held", 64'(timeout_o), 64'd1);
        enable_i = 1'b1;
        step(2);
        check("t5_timeout_clear", 64'(timeout_o), 64'd0);

        // Reset in the middle of capture
        wait_start("t6_m", m);
        step(5);
        rst = 1'b1;
        step(1);
        check("t6_rst_valid", 64'(out_valid_o), 64'd0);
        check("t6_rst_data", out_data_o, 64'd0);
        check("t6_rst_overrun", 64'(overrun_cnt_o), 64'd0);
        check("t6_rst_drop", 64'(drop_cnt_o), 64'd0);
        check("t6_rst_start", 64'(drv_start_o), 64'd0);
        step(2);
        start_cnt = 0;
        ts_track  = 1'b1;
        sbq.delete();
        rst = 1'b0;
        wait_start("t6_n", n);
        step(40);
        check("t6_sb_drained", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
